// File: rtl/aes_inv_round_tail.sv
// AES-128 inverse round back end: AddRoundKey at capture, then a
// column-serial InvMixColumns, with valid/ready on both sides.
module aes_inv_round_tail (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [127:0] in_key,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  typedef enum logic [1:0] {
    IDLE,
    MIX,
    DONE
  } state_e;

  state_e       state_q;
  logic [1:0]   col_q;
  logic [127:0] buf_q;
  logic [31:0]  col_in;
  logic [31:0]  col_out;
  logic [127:0] buf_d;
  logic         accept;

  function automatic logic [7:0] xt(input logic [7:0] b);
    xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // 09/0b/0d/0e built from one xtime chain of a
  function automatic logic [31:0] imc(input logic [31:0] c);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    imc[31:24] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    imc[23:16] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
    imc[15:8]  = md[0] ^ m9[1] ^ me[2] ^ mb[3];
    imc[7:0]   = mb[0] ^ md[1] ^ m9[2] ^ me[3];
  endfunction

  always_comb begin
    col_in = 32'h0;
    buf_d  = buf_q;
    unique case (col_q)
      2'd0: col_in = buf_q[127:96];
      2'd1: col_in = buf_q[95:64];
      2'd2: col_in = buf_q[63:32];
      2'd3: col_in = buf_q[31:0];
    endcase
    col_out = imc(col_in);
    unique case (col_q)
      2'd0: buf_d[127:96] = col_out;
      2'd1: buf_d[95:64]  = col_out;
      2'd2: buf_d[63:32]  = col_out;
      2'd3: buf_d[31:0]   = col_out;
    endcase
  end

  assign in_ready  = (state_q == IDLE) ||
                     (state_q == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign out_state = buf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      buf_q   <= 128'h0;
    end else if (accept) begin
      buf_q   <= in_state ^ in_key;
      col_q   <= 2'd0;
      state_q <= in_last ? DONE : MIX;
    end else begin
      unique case (state_q)
        IDLE: ;
        MIX: begin
          buf_q <= buf_d;
          col_q <= col_q + 2'd1;
          if (col_q == 2'd3) state_q <= DONE;
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_round_tail.sv
// Directed vector bench for aes_inv_round_tail: table of rounds plus
// backpressure, back-to-back and mid-operation reset sequences.
module tb_aes_inv_round_tail;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [127:0] in_key;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  int pass_cnt = 0;
  int total    = 0;

  typedef struct {
    logic [127:0] st;
    logic [127:0] key;
    logic         last;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl [5];

  always #5 clk = ~clk;

  aes_inv_round_tail dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_key    (in_key),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    in_state = v.st;
    in_key   = v.key;
    in_last  = v.last;
  endtask

  // Accept one vector with out_ready high and check latency/result.
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    out_ready = 1'b1;
    drive(v);
    #1;
    chk($sformatf("v%0d in_ready", idx), in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_state = '1;
    in_key   = '1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk($sformatf("v%0d latency", idx), lat, v.last ? 0 : 4);
    chk($sformatf("v%0d out_state", idx), out_state, v.exp);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d valid_drop", idx), out_valid, 1'b0);
  endtask

  initial begin
    vec_t b;
    int   lat;
    int   seen;

    tbl[0] = '{128'hbd6e7c3df2b5779e0b61216e8b10b689,
               128'h549932d1f08557681093ed9cbe2c974e, 1'b0,
               128'h54d990a16ba09ab596bbf40ea111702f};
    tbl[1] = '{128'h00102030405060708090a0b0c0d0e0f0,
               128'h000102030405060708090a0b0c0d0e0f, 1'b1,
               128'h00112233445566778899aabbccddeeff};
    tbl[2] = '{{4{32'h8e4da1bc}}, 128'h0, 1'b0,
               {4{32'hdb135345}}};
    tbl[3] = '{128'h0, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 1'b1,
               128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0};
    tbl[4] = '{{4{32'hdb135345}}, {4{32'hdb135345}}, 1'b0,
               128'h0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_state  = '0;
    in_key    = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst out_state", out_state, 128'h0);
    chk("rst in_ready", in_ready, 1'b1);

    for (int i = 0; i < 5; i++) run_vec(tbl[i], i);

    // Backpressure, then back-to-back capture on the release edge.
    out_ready = 1'b0;
    drive(tbl[0]);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp latency", lat, 4);
    b = tbl[1];
    for (int i = 0; i < 10; i++) begin
      drive(b);
      in_valid = i[0];
      #1;
      chk($sformatf("bp%0d in_ready", i), in_ready, 1'b0);
      chk($sformatf("bp%0d out_valid", i), out_valid, 1'b1);
      chk($sformatf("bp%0d out_state", i), out_state, tbl[0].exp);
      @(posedge clk);
      #1;
    end
    chk("b2b hold", out_state, tbl[0].exp);
    drive(b);
    out_ready = 1'b1;
    #1;
    chk("b2b in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("b2b out_valid", out_valid, 1'b1);
    chk("b2b out_state", out_state, b.exp);
    @(posedge clk);
    #1;
    chk("b2b drain", out_valid, 1'b0);

    // Reset at col = 2 aborts the block.
    drive(tbl[0]);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort out_valid", out_valid, 1'b0);
    chk("abort out_state", out_state, 128'h0);
    chk("abort in_ready", in_ready, 1'b1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("abort no output", seen, 0);
    run_vec(tbl[2], 9);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/aes_inv_round_tail.md
Name: aes_inv_round_tail

Overview:
- Registered decryption-round back end that consumes the InvSubBytes output.
- Applies AddRoundKey (state XOR round key) followed by InvMixColumns.
- InvMixColumns is serialized one 32-bit column per cycle, sharing one column multiplier.
- A last-round flag bypasses InvMixColumns. Valid/ready handshakes on both sides let the block sit between the InvShiftRows/InvSubBytes logic and the round-state register of the iterative decryptor.

Parameters:
- None. The AES-128 state is fixed at 128 bits and the column count is fixed at 4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_state/in_key/in_last valid
- in_ready  output  1  block can accept input this cycle
- in_state  input  128  state from InvSubBytes; byte0 = [127:120]; column c = bytes 4c..4c+3 (column 0 = [127:96])
- in_key  input  128  round key, same byte order
- in_last  input  1  1 = final round, skip InvMixColumns
- out_valid  output  1  out_state valid
- out_ready  input  1  consumer accepts out_state this cycle
- out_state  output  128  round result, same byte order

Behaviour:
- Reset: synchronous, active-high. One clock and one synchronous, active-high reset (clk, rst).
  - State returns to IDLE; column counter = 0; data buffer = 0.
  - out_valid = 0, out_state = 0, in_ready = 1 in the cycle after reset is sampled.
  - Reset mid-operation discards the block in flight; no output is produced for it.
- FSM states: IDLE, MIX, DONE.
- in_ready = (state == IDLE) || (state == DONE && out_ready).
- Accept = in_valid && in_ready.
  - On accept: buf <= in_state ^ in_key (AddRoundKey is done at capture).
  - If in_last = 1, go to DONE. Otherwise go to MIX with col = 0.
- MIX: each cycle, column col of buf is replaced by InvMixColumns(column).
  - Column math: o0=0e·a0^0b·a1^0d·a2^09·a3; o1=09·a0^0e·a1^0b·a2^0d·a3; o2=0d·a0^09·a1^0e·a2^0b·a3; o3=0b·a0^0d·a1^09·a2^0e·a3.
  - Multiplication is in GF(2^8) with the polynomial 0x11B (xtime chains, no tables).
  - col increments each cycle. On the edge that processes col = 3, col wraps to 0 and the state goes to DONE.
- DONE: out_valid = 1 and out_state = buf.
  - out_state and out_valid hold stable while out_ready = 0.
  - On out_ready = 1: with no simultaneous accept, go to IDLE. With a simultaneous accept (in_valid = 1), the new block is captured on the same edge. The old block is considered delivered and the next state follows the in_last rule.
- Latency, counted from the accepting edge k:
  - Normal round: out_valid rises after edge k+4 (4 MIX cycles).
  - Last round: out_valid rises after edge k.
- Throughput: one normal block per 5 cycles, one last-round block per cycle when back-to-back.
- in_valid while busy (MIX, or DONE without out_ready) is ignored. The inputs are not sampled, and the upstream holds them per the handshake.
- out_valid never asserts in IDLE or MIX.
- out_state in IDLE/MIX is don't-care for checking; the implementation holds the last buf value.
- The input buses are sampled only on the accept edge. Changes to them at other times have no effect.

Test Plan:
- FIPS-197 C.1 round 9:
  - Stimulus: in_state=bd6e7c3df2b5779e0b61216e8b10b689, in_key=549932d1f08557681093ed9cbe2c974e, in_last=0, out_ready=1.
  - Required: out_state=54d990a16ba09ab596bbf40ea111702f, with out_valid rising 4 cycles after accept and high for exactly 1 cycle.
- Last round:
  - Stimulus: in_state=00102030405060708090a0b0c0d0e0f0, in_key=000102030405060708090a0b0c0d0e0f, in_last=1.
  - Required: out_state=00112233445566778899aabbccddeeff, with out_valid high in the cycle after accept.
- Column math:
  - Stimulus: in_state=8e4da1bc repeated 4 times, in_key=0, in_last=0.
  - Required: out_state=db135345 repeated 4 times.
- Backpressure:
  - Stimulus: the normal vector from the first scenario with out_ready=0 for 10 cycles after out_valid rises; toggle in_valid with a different vector during that time.
  - Required: out_state holds 54d990a1…, in_ready=0 throughout, and the second vector is not captured until the out_ready=1 edge.
- Back-to-back:
  - Stimulus: in DONE, raise out_ready=1 and in_valid=1 together with the last-round vector.
  - Required: first result delivered, second captured on the same edge, and 00112233…eeff valid on the next cycle with no IDLE bubble.
- Reset mid-MIX:
  - Stimulus: assert rst for 1 cycle at col=2.
  - Required: out_valid=0, out_state=0 and in_ready=1 next cycle, no output ever for the aborted block, and a new vector then completes correctly.
